// File: rtl/mil_rt_ctrl_if.sv
// Word-level bus bundle between the 1553 RT sequencer, the word receiver/transmitter and the
// subaddress buffer. master = sequencer side, slave = environment side.
interface mil_rt_ctrl_if;
   logic        word_stb;
   logic [15:0] word_dat;
   logic        word_cw;
   logic        word_par_ok;
   logic        buf_we;
   logic [9:0]  buf_addr;
   logic [15:0] buf_wdat;
   logic [15:0] buf_rdat;
   logic        tx_req;
   logic        tx_cw;
   logic [15:0] tx_dat;
   logic        tx_ack;

   modport master (
      input  word_stb, word_dat, word_cw, word_par_ok, buf_rdat, tx_ack,
      output buf_we, buf_addr, buf_wdat, tx_req, tx_cw, tx_dat
   );

   modport slave (
      output word_stb, word_dat, word_cw, word_par_ok, buf_rdat, tx_ack,
      input  buf_we, buf_addr, buf_wdat, tx_req, tx_cw, tx_dat
   );
endinterface

// File: rtl/mil_rt_ctrl.sv
// MIL-STD-1553 remote-terminal message sequencer: command decode, data buffering, status/data replies.
// Optional mode-code handling on SA 0/31 is enabled by defining MIL_RT_MODECODE_EN.
module mil_rt_ctrl #(
   parameter int unsigned RESP_GAP   = 250,
   parameter int unsigned WORD_TMO   = 1100,
   parameter int unsigned BCAST_ADDR = 31
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [4:0]   rt_addr,
   mil_rt_ctrl_if.master bus,
   output logic         msg_done,
   output logic         msg_err,
   output logic         busy
);

   localparam int unsigned GAP_W = $clog2(RESP_GAP + 1);
   localparam int unsigned TMO_W = $clog2(WORD_TMO + 1);

   typedef enum logic [2:0] {IDLE, RX_DATA, GAP, TX_STATUS, TX_DATA} state_t;

   state_t             state;
   logic [4:0]         sa_l, own_l, widx;
   logic [5:0]         n_l, cnt;
   logic               tr_l, bc_l, rd_wait, me_flag, bcr_flag;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic               buf_we_q, tx_req_q, tx_cw_q;
   logic [9:0]         buf_addr_q;
   logic [15:0]        buf_wdat_q, tx_dat_q;

   logic [4:0]         c_addr, c_sa, c_wc, c_sa_eff, c_idx0;
   logic [5:0]         c_n;
   logic               c_tr, c_bc, c_hit, c_nodata, sup, take_cmd;

   assign bus.buf_we   = buf_we_q;
   assign bus.buf_addr = buf_addr_q;
   assign bus.buf_wdat = buf_wdat_q;
   assign bus.tx_req   = tx_req_q;
   assign bus.tx_cw    = tx_cw_q;
   assign bus.tx_dat   = tx_dat_q;
   assign busy         = (state != IDLE);

   always_comb begin
      c_addr   = bus.word_dat[15:11];
      c_tr     = bus.word_dat[10];
      c_sa     = bus.word_dat[9:5];
      c_wc     = bus.word_dat[4:0];
      c_bc     = (c_addr == 5'(BCAST_ADDR));
      c_hit    = bus.word_stb & bus.word_cw & bus.word_par_ok & ((c_addr == rt_addr) | c_bc);
      c_n      = (c_wc == 5'd0) ? 6'd32 : {1'b0, c_wc};
      c_sa_eff = c_sa;
      c_idx0   = '0;
      c_nodata = 1'b0;
`ifdef MIL_RT_MODECODE_EN
      // Mode codes reuse the word index as the code so the single data word lands at {0, code}.
      if (c_sa == 5'd0 || c_sa == 5'd31) begin
         c_sa_eff = '0;
         c_idx0   = c_wc;
         c_nodata = ~c_wc[4];
         c_n      = c_wc[4] ? 6'd1 : 6'd0;
      end
`endif
      sup      = (state == RX_DATA) & bus.word_stb & bus.word_cw & bus.word_par_ok;
      take_cmd = c_hit & ((state == IDLE) | (state == RX_DATA));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sa_l       <= '0;
         own_l      <= '0;
         widx       <= '0;
         n_l        <= '0;
         cnt        <= '0;
         tr_l       <= 1'b0;
         bc_l       <= 1'b0;
         rd_wait    <= 1'b0;
         me_flag    <= 1'b0;
         bcr_flag   <= 1'b0;
         tmo_cnt    <= '0;
         gap_cnt    <= '0;
         buf_we_q   <= 1'b0;
         buf_addr_q <= '0;
         buf_wdat_q <= '0;
         tx_req_q   <= 1'b0;
         tx_cw_q    <= 1'b0;
         tx_dat_q   <= '0;
         msg_done   <= 1'b0;
         msg_err    <= 1'b0;
      end else begin
         buf_we_q <= 1'b0;
         msg_done <= 1'b0;
         msg_err  <= 1'b0;

         case (state)
            RX_DATA: begin
               if (bus.word_stb && !bus.word_par_ok) begin
                  me_flag <= 1'b1;
                  msg_err <= 1'b1;
                  state   <= IDLE;
               end else if (bus.word_stb && bus.word_cw) begin
                  // Superseding command; the accept block below may redirect the state.
                  msg_err <= 1'b1;
                  state   <= IDLE;
               end else if (bus.word_stb) begin
                  buf_we_q   <= 1'b1;
                  buf_addr_q <= {sa_l, widx};
                  buf_wdat_q <= bus.word_dat;
                  widx       <= widx + 5'd1;
                  cnt        <= cnt + 6'd1;
                  tmo_cnt    <= '0;
                  if (cnt + 6'd1 == n_l) begin
                     if (bc_l) begin
                        bcr_flag <= 1'b1;
                        msg_done <= 1'b1;
                        state    <= IDLE;
                     end else begin
                        gap_cnt <= '0;
                        state   <= GAP;
                     end
                  end
               end else if (tmo_cnt == TMO_W'(WORD_TMO - 1)) begin
                  me_flag <= 1'b1;
                  msg_err <= 1'b1;
                  state   <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            GAP: begin
               if (gap_cnt == GAP_W'(RESP_GAP - 1)) begin
                  tx_req_q <= 1'b1;
                  tx_cw_q  <= 1'b1;
                  tx_dat_q <= {own_l, me_flag, 5'b0, bcr_flag, 4'b0};
                  state    <= TX_STATUS;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            TX_STATUS: begin
               if (tx_req_q && bus.tx_ack) begin
                  tx_req_q <= 1'b0;
                  me_flag  <= 1'b0;
                  bcr_flag <= 1'b0;
                  if (tr_l && n_l != 6'd0) begin
                     buf_addr_q <= {sa_l, widx};
                     rd_wait    <= 1'b0;
                     state      <= TX_DATA;
                  end else begin
                     msg_done <= 1'b1;
                     state    <= IDLE;
                  end
               end
            end

            TX_DATA: begin
               // Two cycles with tx_req low: address settle, then synchronous buffer read.
               if (!tx_req_q) begin
                  if (!rd_wait) begin
                     rd_wait <= 1'b1;
                  end else begin
                     tx_req_q <= 1'b1;
                     tx_cw_q  <= 1'b0;
                     tx_dat_q <= bus.buf_rdat;
                     rd_wait  <= 1'b0;
                  end
               end else if (bus.tx_ack) begin
                  tx_req_q <= 1'b0;
                  widx     <= widx + 5'd1;
                  cnt      <= cnt + 6'd1;
                  if (cnt + 6'd1 == n_l) begin
                     msg_done <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     buf_addr_q <= {sa_l, widx + 5'd1};
                  end
               end
            end

            default: state <= IDLE;
         endcase

         if (take_cmd) begin
            sa_l    <= c_sa_eff;
            n_l     <= c_n;
            tr_l    <= c_tr;
            bc_l    <= c_bc;
            own_l   <= rt_addr;
            widx    <= c_idx0;
            cnt     <= '0;
            tmo_cnt <= '0;
            gap_cnt <= '0;
            if (c_nodata) begin
               if (c_bc) begin
                  msg_done <= ~sup;
                  state    <= IDLE;
               end else begin
                  state <= GAP;
               end
            end else if (!c_tr) begin
               state <= RX_DATA;
            end else if (!c_bc) begin
               state <= GAP;
            end else begin
               me_flag <= 1'b1;
               msg_err <= 1'b1;
               state   <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_mil_rt_ctrl.sv
// Self-checking bench for mil_rt_ctrl: table of messages plus hand sequences for timeout,
// superseding command and reset during transmit; buffer writes and tx words go through scoreboards.
module tb_mil_rt_ctrl;
   localparam int unsigned RESP_GAP = 250;
   localparam int unsigned WORD_TMO = 1100;
   localparam int unsigned NONE     = 255;

   typedef struct {
      logic [15:0] cmd;
      int unsigned ndata;
      logic [15:0] d0;
      int unsigned bad_at;
      bit          has_st;
      logic [15:0] st;
      bit          exp_err;
      bit          ign;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  rt_addr = 5'd5;
   logic        msg_done, msg_err, busy;
   logic        pl_we = 1'b0;
   logic [9:0]  pl_addr = '0;
   logic [15:0] pl_dat = '0;
   logic [15:0] mem [0:1023];
   logic [15:0] exp_mem [0:1023];
   logic [31:0] exp_wr[$];
   logic [31:0] exp_tx[$];
   int unsigned n_chk = 0, n_pass = 0;
   int unsigned n_done = 0, n_err = 0, n_ack = 0;
   int unsigned cyc = 0, err_cyc = 0, st_cyc = 0, last_stb_cyc = 0;
   vec_t        vecs[11];

   mil_rt_ctrl_if bus();

   mil_rt_ctrl #(.RESP_GAP(RESP_GAP), .WORD_TMO(WORD_TMO), .BCAST_ADDR(31)) dut (
      .clk(clk), .rst_n(rst_n), .rt_addr(rt_addr), .bus(bus),
      .msg_done(msg_done), .msg_err(msg_err), .busy(busy)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (pl_we) mem[pl_addr] <= pl_dat;
      else if (bus.buf_we) mem[bus.buf_addr] <= bus.buf_wdat;
      bus.buf_rdat <= mem[bus.buf_addr];
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endfunction

   initial begin : mon
      int unsigned hold;
      bit          inreq;
      logic [31:0] e;
      hold = 0;
      inreq = 0;
      bus.tx_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bus.tx_ack = 1'b0;
            inreq = 0;
         end else begin
            if (msg_done || msg_err) chk("pulse_excl", 32'(msg_done & msg_err), 32'd0);
            if (msg_done) n_done++;
            if (msg_err) begin n_err++; err_cyc = cyc; end
            if (bus.buf_we) begin
               if (exp_wr.size() == 0) begin
                  n_chk++;
                  $display("FAIL wr_unexpected: got addr %h data %h, expected no write", bus.buf_addr, bus.buf_wdat);
               end else begin
                  e = exp_wr.pop_front();
                  chk("buf_write", {6'b0, bus.buf_addr, bus.buf_wdat}, e);
               end
            end
            if (bus.tx_ack) begin
               bus.tx_ack = 1'b0;
               chk("tx_req_drop", 32'(bus.tx_req), 32'd0);
               inreq = 0;
            end else if (bus.tx_req) begin
               if (!inreq) begin
                  inreq = 1;
                  if (bus.tx_cw) st_cyc = cyc;
                  if (exp_tx.size() == 0) begin
                     n_chk++;
                     $display("FAIL tx_unexpected: got cw %b dat %h, expected no request", bus.tx_cw, bus.tx_dat);
                  end else begin
                     e = exp_tx.pop_front();
                     chk("tx_word", {15'b0, bus.tx_cw, bus.tx_dat}, e);
                  end
                  hold = $urandom_range(0, 2);
               end
               if (hold == 0) begin bus.tx_ack = 1'b1; n_ack++; end
               else hold--;
            end
         end
      end
   end

   task automatic send_word(input logic [15:0] d, input logic cw, input logic pok);
      @(negedge clk);
      bus.word_stb = 1'b1;
      bus.word_dat = d;
      bus.word_cw = cw;
      bus.word_par_ok = pok;
      @(negedge clk);
      bus.word_stb = 1'b0;
      last_stb_cyc = cyc;
   endtask

   task automatic wait_evt(input int unsigned target, input int unsigned bound);
      int unsigned k = 0;
      while (n_done + n_err < target && k < bound) begin
         @(negedge clk); #1;
         k++;
      end
      if (n_done + n_err < target) begin
         n_chk++;
         $display("FAIL msg_wait: got no msg pulse within %0d cycles, expected one", bound);
      end
   endtask

   task automatic settle_checks();
      repeat (4) @(negedge clk);
      #1;
      chk("tx_q_empty", exp_tx.size(), 32'd0);
      chk("wr_q_empty", exp_wr.size(), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      exp_tx.delete();
      exp_wr.delete();
   endtask

   task automatic run_vec(input vec_t v);
      logic [4:0]  sa = v.cmd[9:5];
      int unsigned n = (v.cmd[4:0] == 5'd0) ? 32 : int'(v.cmd[4:0]);
      int unsigned d0 = n_done, e0 = n_err;
      logic [15:0] d;
      if (v.has_st) exp_tx.push_back({15'b0, 1'b1, v.st});
      if (v.cmd[10] && !v.exp_err && !v.ign)
         for (int unsigned i = 0; i < n; i++) exp_tx.push_back({15'b0, 1'b0, exp_mem[{sa, 5'(i)}]});
      send_word(v.cmd, 1'b1, 1'b1);
      if (!v.cmd[10]) begin
         for (int unsigned i = 0; i < v.ndata; i++) begin
            d = (i % 2 == 1) ? ~v.d0 : v.d0;
            if (i == v.bad_at) begin
               send_word(d, 1'b0, 1'b0);
               break;
            end
            exp_wr.push_back({6'b0, sa, 5'(i), d});
            exp_mem[{sa, 5'(i)}] = d;
            send_word(d, 1'b0, 1'b1);
         end
      end
      if (v.ign) begin
         repeat (20) @(negedge clk);
         #1;
         chk("ign_no_done", n_done - d0, 32'd0);
         chk("ign_no_err", n_err - e0, 32'd0);
         chk("ign_busy", 32'(busy), 32'd0);
         return;
      end
      wait_evt(d0 + e0 + 1, 4000);
      chk("msg_done", n_done - d0, v.exp_err ? 32'd0 : 32'd1);
      chk("msg_err", n_err - e0, v.exp_err ? 32'd1 : 32'd0);
      if (v.has_st) chk("resp_gap", st_cyc - last_stb_cyc, RESP_GAP);
      settle_checks();
   endtask

   initial begin : wdog
      #4000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin : main
      int unsigned d0, e0, a0, k;
      vec_t post;
      bus.word_stb = 1'b0;
      bus.word_dat = '0;
      bus.word_cw = 1'b0;
      bus.word_par_ok = 1'b0;

      vecs[0]  = '{16'h2862, 2, 16'hA5A5, NONE, 1, 16'h2800, 0, 0};
      vecs[1]  = '{16'h2C20, 0, 16'h0000, NONE, 1, 16'h2800, 0, 0};
      vecs[2]  = '{16'hF841, 1, 16'h1234, NONE, 0, 16'h0000, 0, 0};
      vecs[3]  = '{16'h28A1, 1, 16'hC3C3, NONE, 1, 16'h2810, 0, 0};
      vecs[4]  = '{16'h2883, 3, 16'h0F0F, 1,    0, 16'h0000, 1, 0};
      vecs[5]  = '{16'h2841, 1, 16'h7E81, NONE, 1, 16'h2C00, 0, 0};
      vecs[6]  = '{16'hFC21, 0, 16'h0000, NONE, 0, 16'h0000, 1, 0};
      vecs[7]  = '{16'h3062, 0, 16'h0000, NONE, 0, 16'h0000, 0, 1};
      vecs[8]  = '{16'h2C23, 0, 16'h0000, NONE, 1, 16'h2C00, 0, 0};
      vecs[9]  = '{16'hF822, 2, 16'h9999, NONE, 0, 16'h0000, 0, 0};
      vecs[10] = '{16'h2C20, 0, 16'h0000, NONE, 1, 16'h2810, 0, 0};

      repeat (3) @(negedge clk);
      #1;
      chk("rst_tx_req", 32'(bus.tx_req), 32'd0);
      chk("rst_tx_cw", 32'(bus.tx_cw), 32'd0);
      chk("rst_tx_dat", 32'(bus.tx_dat), 32'd0);
      chk("rst_buf_we", 32'(bus.buf_we), 32'd0);
      chk("rst_buf_addr", 32'(bus.buf_addr), 32'd0);
      chk("rst_msg", {30'b0, msg_done, msg_err}, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      for (int unsigned i = 0; i < 32; i++) begin
         @(negedge clk);
         pl_we = 1'b1;
         pl_addr = {5'd1, 5'(i)};
         pl_dat = 16'($urandom);
         exp_mem[{5'd1, 5'(i)}] = pl_dat;
      end
      @(negedge clk);
      pl_we = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int unsigned i = 0; i < 11; i++) run_vec(vecs[i]);

      // Timeout: one of two words, then silence.
      d0 = n_done; e0 = n_err;
      send_word(16'h2862, 1'b1, 1'b1);
      exp_wr.push_back({6'b0, 5'd3, 5'd0, 16'hBEEF});
      send_word(16'hBEEF, 1'b0, 1'b1);
      a0 = last_stb_cyc;
      wait_evt(d0 + e0 + 1, WORD_TMO + 100);
      chk("tmo_err", n_err - e0, 32'd1);
      chk("tmo_done", n_done - d0, 32'd0);
      chk("tmo_cycles", err_cyc - a0, WORD_TMO);
      settle_checks();

      // Superseding command mid-message, then a clean message with the error flag reported.
      d0 = n_done; e0 = n_err;
      exp_wr.push_back({6'b0, 5'd3, 5'd0, 16'h1111});
      exp_wr.push_back({6'b0, 5'd5, 5'd0, 16'h2222});
      exp_tx.push_back({15'b0, 1'b1, 16'h2C00});
      send_word(16'h2862, 1'b1, 1'b1);
      send_word(16'h1111, 1'b0, 1'b1);
      send_word(16'h28A1, 1'b1, 1'b1);
      chk("sup_err_now", n_err - e0, 32'd1);
      send_word(16'h2222, 1'b0, 1'b1);
      wait_evt(d0 + e0 + 2, 2000);
      chk("sup_err", n_err - e0, 32'd1);
      chk("sup_done", n_done - d0, 32'd1);
      chk("sup_gap", st_cyc - last_stb_cyc, RESP_GAP);
      settle_checks();

      // Reset while transmit data words are in flight.
      d0 = n_done; e0 = n_err; a0 = n_ack;
      exp_tx.push_back({15'b0, 1'b1, 16'h2800});
      for (int unsigned i = 0; i < 32; i++) exp_tx.push_back({15'b0, 1'b0, exp_mem[{5'd1, 5'(i)}]});
      send_word(16'h2C20, 1'b1, 1'b1);
      k = 0;
      while (!(n_ack >= a0 + 5 && bus.tx_req) && k < 2000) begin
         @(negedge clk); #1;
         k++;
      end
      chk("rst_reach_txdata", 32'(n_ack >= a0 + 5 && bus.tx_req), 32'd1);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_tx_req", 32'(bus.tx_req), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_msg", {30'b0, msg_done, msg_err}, 32'd0);
      exp_tx.delete();
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("midrst_no_done", n_done - d0, 32'd0);
      chk("midrst_no_err", n_err - e0, 32'd0);
      post = '{16'h2C23, 0, 16'h0000, NONE, 1, 16'h2800, 0, 0};
      run_vec(post);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mil_rt_ctrl.md
Name: mil_rt_ctrl

Overview:
MIL-STD-1553 remote-terminal message sequencer, placed downstream of the Manchester word receiver.
- Consumes decoded words (16-bit data, sync type, parity verdict) and decodes command words addressed to this RT or to broadcast.
- Writes received data words into a subaddress-indexed buffer; sequences the response gap, status word and transmit data words to the word transmitter through a req/ack handshake.
- Reports message completion and error events.

Parameters:
RESP_GAP, 250, clk cycles from end of last received word to status request (5 us at 50 MHz)
WORD_TMO, 1100, max clk cycles between consecutive word_stb in RX_DATA before timeout
BCAST_ADDR, 31, broadcast RT address

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
rt_addr  in  5  own RT address, sampled at command acceptance
word_stb  in  1  one-cycle pulse: new decoded word valid
word_dat  in  16  decoded word, MSB first as received
word_cw  in  1  1 = command/status sync, 0 = data sync
word_par_ok  in  1  odd parity correct
buf_we  out  1  buffer write strobe, one cycle
buf_addr  out  10  {subaddress[4:0], word index[4:0]}
buf_wdat  out  16  buffer write data
buf_rdat  in  16  buffer read data, valid 1 cycle after buf_addr
tx_req  out  1  word transmit request, held until tx_ack
tx_cw  out  1  sync type of requested word
tx_dat  out  16  word to transmit
tx_ack  in  1  one-cycle acknowledge of tx_req
msg_done  out  1  one-cycle pulse: message completed cleanly
msg_err  out  1  one-cycle pulse: message aborted
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; me_flag = 0, bcr_flag = 0, counters 0.
- Command fields: [15:11] addr, [10] T/R, [9:5] SA, [4:0] WC; WC = 0 means 32 words (N = 32, 6-bit count).
- IDLE: accept on word_stb & word_cw & word_par_ok & (addr == rt_addr | addr == BCAST_ADDR).
  - Latch SA, N, T/R, bcast; idx = 0.
  - T/R = 0 -> RX_DATA.
  - T/R = 1 and not broadcast -> GAP.
  - T/R = 1 and broadcast -> illegal: set me_flag, pulse msg_err, stay IDLE.
  - All other words are ignored.
- RX_DATA:
  - Valid data word (stb & !cw & par_ok): the next cycle drives buf_we = 1, buf_addr = {SA, idx}, buf_wdat = word_dat; idx++. Tmo counter restarts.
  - After the N-th word: broadcast -> set bcr_flag, pulse msg_done, go IDLE; otherwise go GAP.
  - Parity error, or tmo counter reaching WORD_TMO: set me_flag, pulse msg_err, go IDLE; no status is sent.
  - Valid command (stb & cw & par_ok) arriving mid-message: supersedes. Pulse msg_err, set no flag, re-decode in the same cycle as in IDLE.
- GAP:
  - Counter runs from 0; at RESP_GAP-1 go TX_STATUS.
  - word_stb is ignored here, and in all TX states.
- TX_STATUS:
  - tx_req = 1, tx_cw = 1, tx_dat = {rt_addr, me_flag, 5'b0, bcr_flag, 4'b0}.
  - On tx_ack: tx_req drops the next cycle, me_flag and bcr_flag clear.
  - Then T/R = 1 -> TX_DATA; else pulse msg_done and go IDLE.
- TX_DATA:
  - buf_addr = {SA, idx}; wait 1 cycle for buf_rdat.
  - Raise tx_req with tx_cw = 0, tx_dat = buf_rdat; hold until tx_ack, then idx++.
  - After N acks: pulse msg_done, go IDLE.
  - No tmo applies to tx_ack.
- tx_req never asserts in the same cycle as tx_ack for the previous word; minimum 1 idle cycle between requests.
- tx_ack while tx_req = 0 is ignored.
- msg_done and msg_err are never asserted together.
- Reset mid-message: immediate IDLE; outputs 0; no pulse.

Optional Feature:
MIL_RT_MODECODE_EN
- Defined: SA = 0 or SA = 31 marks a mode command; the WC field is the mode code.
  - Code[4] = 0: no data words. Go straight to GAP (T/R = 1) or GAP after command (T/R = 0); broadcast -> msg_done, no status.
  - Code[4] = 1: exactly one data word at buf_addr {5'd0, code[4:0]}, direction per T/R.
- Undefined: SA 0 and 31 are ordinary subaddresses using WC.

Test Plan:
- rt_addr = 5, cmd 16'h2862 (addr 5, R, SA 3, WC 2), 2 data words 16'hA5A5, 16'h5A5A -> buf_we at addr 10'h060 and 10'h061; tx_req after RESP_GAP with tx_dat = 16'h2800; msg_done after ack.
- Cmd 16'h2C20 (addr 5, T, SA 1, WC 0), buffer preloaded -> status 16'h2800 then 32 data words from buf_addr 10'h020..10'h03F in order; msg_done.
- Broadcast 16'hF841 (R, SA 2, WC 1) + 1 data word -> buf_we at 10'h040; no tx_req; msg_done. Next valid command -> status = 16'h2810.
- R cmd WC 3, second data word with word_par_ok = 0 -> msg_err, no tx_req. Next command's status = 16'h2C00.
- R cmd WC 2, only 1 data word, then silence -> msg_err exactly WORD_TMO cycles after the first word's stb.
- Assert rst_n = 0 during TX_DATA -> tx_req = 0 and busy = 0 immediately; no msg pulse; next command handled normally.
